// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative encryptor.
//   NR          number of AES-128 rounds
//   aes_state_t 128-bit block/key type; byte 0 is bits [127:120], column-major
//   aes_fsm_t   controller states
//   RCON        round constant table, indexed by round number (1..10)
//   xtime/gf_mul/sbox  GF(2^8) helpers; the S-box is computed as the field
//               inverse (x^254) followed by the affine transform.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_fsm_t;

  // Entries past round 10 are never used by a live round; padded so any
  // 4-bit round number indexes safely.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    // inv accumulates x^2 * x^4 * ... * x^128 = x^254 (0 maps to 0)
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational datapath: R consecutive AES rounds with on-the-fly key
// expansion.
//   state      block entering round rnd
//   rk         round key of round rnd-1
//   rnd        number of the first round applied here
//   next_state block after round rnd+R-1
//   next_rk    round key of round rnd+R-1
// Round NR skips MixColumns; that is decided per stage from its round number.
module aes_round_unit
  import aes_pkg::*;
#(
  parameter int R = 1
) (
  input  aes_state_t state,
  input  aes_state_t rk,
  input  logic [3:0] rnd,
  output aes_state_t next_state,
  output aes_state_t next_rk
);

  function automatic aes_state_t sub_shift(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic aes_state_t mix_cols(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic aes_state_t key_step(input aes_state_t k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    // SubWord(RotWord(w3)) ^ rcon
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [R:0][127:0] st_c;
  logic [R:0][127:0] rk_c;

  assign st_c[0] = state;
  assign rk_c[0] = rk;

  for (genvar i = 0; i < R; i++) begin : g_rnd
    logic [3:0] rn;
    aes_state_t k_n, sr;
    assign rn          = rnd + 4'(i);
    assign k_n         = key_step(rk_c[i], RCON[rn]);
    assign sr          = sub_shift(st_c[i]);
    assign rk_c[i+1]   = k_n;
    assign st_c[i+1]   = ((rn == 4'(NR)) ? sr : mix_cols(sr)) ^ k_n;
  end

  assign next_state = st_c[R];
  assign next_rk    = rk_c[R];

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock.
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data, in_key, in_tag sampled on accept
//   out_valid/out_ready output handshake; out_data, out_tag held until accepted
//   busy                high while rounds are being computed
//   ctr_load/ctr_init   counter load (only with AES_CTR_MODE_EN)
// Build option: AES_CTR_MODE_EN -- encrypt an internal 128-bit counter and
// XOR the result with the captured in_data; otherwise plain ECB on in_data.
// Block accepted at edge T is valid from edge T+10/ROUNDS_PER_CYCLE.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TAG_W            = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef AES_CTR_MODE_EN
  ,
  input  logic             ctr_load,
  input  logic [127:0]     ctr_init
`endif
);

  localparam int R = ROUNDS_PER_CYCLE;
  // round number processed in the final RUN cycle
  localparam logic [3:0] LAST_RND = 4'(NR + 1 - R);

  if (!(R == 1 || R == 2 || R == 5 || R == 10)) begin : g_bad_r
    $error("aes_enc_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  aes_fsm_t         state_q, state_d;
  aes_state_t       st_q, rk_q, st_nx, rk_nx;
  aes_state_t       blk, mask;
  logic [3:0]       rnd_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept, last;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = (state_q == RUN) && (rnd_q == LAST_RND);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);

`ifdef AES_CTR_MODE_EN
  aes_state_t ctr_q, ctr_use, dat_q;

  // a load coinciding with an accept feeds that same block
  assign ctr_use = ctr_load ? ctr_init : ctr_q;
  assign blk     = ctr_use;
  assign mask    = dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q <= '0;
      dat_q <= '0;
    end else if (accept) begin
      ctr_q <= ctr_use + 128'd1;
      dat_q <= in_data;
    end else if (ctr_load) begin
      ctr_q <= ctr_init;
    end
  end
`else
  assign blk  = in_data;
  assign mask = '0;
`endif

  aes_round_unit #(.R(R)) u_round (
    .state      (st_q),
    .rk         (rk_q),
    .rnd        (rnd_q),
    .next_state (st_nx),
    .next_rk    (rk_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        st_q  <= blk ^ in_key;
        rk_q  <= in_key;
        rnd_q <= 4'd1;
        tag_q <= in_tag;
      end else if (state_q == RUN) begin
        st_q  <= st_nx;
        rk_q  <= rk_nx;
        rnd_q <= rnd_q + 4'(R);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (accept) state_d = RUN;
               else if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // st_q only changes in RUN or on accept, so the result is stable in DONE
  assign out_data = st_q ^ mask;
  assign out_tag  = tag_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Scoreboard bench for aes_enc_iter: one DUT per unroll factor (1,2,5,10),
// each with its own driver, monitor and expected-result queue, checked
// against a byte-array AES-128 reference model built from log/antilog tables.
module tb_aes_enc_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit done [4];
  logic [7:0] sbx [256];

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
  } exp_t;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box from powers of the generator 3: inverse(x) = g^(255 - log x)
  initial begin : build_sbox
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] p, v;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      v = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      sbx[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k[0] = k[0] ^ sbx[k[13]] ^ rc;
      k[1] = k[1] ^ sbx[k[14]];
      k[2] = k[2] ^ sbx[k[15]];
      k[3] = k[3] ^ sbx[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = sbx[s[4*((c+w)%4)+w]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
          for (int j = 0; j < 4; j++)
            t[4*c+j] = xt(a[j]) ^ xt(a[(j+1)%4]) ^ a[(j+1)%4] ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int R    = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 5 : 10;
    localparam int NCYC = 10 / R;

    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, in_key, out_data;
    logic [3:0]   in_tag, out_tag;
    logic         rdy_drv, rr_en, rr_bit;
    exp_t         q [$];
    int           nxfer = 0;
`ifdef AES_CTR_MODE_EN
    logic         ctr_load, ld_req;
    logic [127:0] ctr_init, ld_val, ctr_m;
`endif

    assign out_ready = rr_en ? rr_bit : rdy_drv;

    aes_enc_iter #(.ROUNDS_PER_CYCLE(R), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
`ifdef AES_CTR_MODE_EN
      ,
      .ctr_load  (ctr_load),
      .ctr_init  (ctr_init)
`endif
    );

    initial forever begin
      @(posedge clk);
      #1 rr_bit = ($urandom_range(0, 3) != 0);
    end

    // monitor: a transfer happens at the posedge following a negedge with valid && ready
    initial forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        exp_t e;
        nxfer++;
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL R%0d unexpected output: got %h tag %0d, none expected", R, out_data, out_tag);
        end else begin
          e = q.pop_front();
          chk($sformatf("R%0d out_data", R), out_data, e.data);
          chk($sformatf("R%0d out_tag", R), {124'h0, out_tag}, {124'h0, e.tag});
        end
      end
    end

    // push=0 leaves the block off the scoreboard; use_kat substitutes a known answer
    task automatic send(input logic [127:0] key, input logic [127:0] data, input logic [3:0] tag,
                        input bit push, input bit use_kat, input logic [127:0] kat);
      int t;
      logic [127:0] blk, ex;
      in_key = key;
      in_data = data;
      in_tag = tag;
      in_valid = 1'b1;
`ifdef AES_CTR_MODE_EN
      ctr_load = ld_req;
      ctr_init = ld_val;
`endif
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        vecs++;
        errs++;
        $display("FAIL R%0d accept timeout: in_ready stuck at 0, expected 1", R);
      end else begin
        blk = data;
        ex  = 128'h0;
`ifdef AES_CTR_MODE_EN
        blk = ld_req ? ld_val : ctr_m;
        ctr_m = blk + 128'd1;
        ex = data;
`endif
        ex = aes_ref(key, blk) ^ ex;
        if (use_kat) ex = kat;
        if (push) q.push_back('{ex, tag});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_key = rnd128();
      in_data = rnd128();
`ifdef AES_CTR_MODE_EN
      ctr_load = 1'b0;
      ld_req = 1'b0;
`endif
    endtask

    task automatic drain();
      int t;
      rr_en = 1'b0;
      rdy_drv = 1'b1;
      t = 0;
      while (q.size() != 0 && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (q.size() != 0) begin
        vecs++;
        errs++;
        $display("FAIL R%0d drain timeout: %0d results outstanding, expected 0", R, q.size());
      end
      @(posedge clk);
      #1;
    endtask

    task automatic latency_check(input string name);
      int k;
      for (k = 0; k <= NCYC + 4; k++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      chk($sformatf("R%0d %s latency", R, name), 128'(k), 128'(NCYC));
      @(posedge clk);
      #1 rdy_drv = 1'b1;
    endtask

    initial begin : driver
      int n0, kk;
      logic [127:0] k, d;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_key = '0;
      in_tag = '0;
      rdy_drv = 1'b0;
      rr_en = 1'b0;
`ifdef AES_CTR_MODE_EN
      ctr_load = 1'b0;
      ctr_init = '0;
      ld_req = 1'b0;
      ld_val = '0;
      ctr_m = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("R%0d reset out_valid", R), 128'(out_valid), 128'h0);
      chk($sformatf("R%0d reset busy", R), 128'(busy), 128'h0);
      chk($sformatf("R%0d reset out_data", R), out_data, 128'h0);
      chk($sformatf("R%0d reset out_tag", R), 128'(out_tag), 128'h0);
      chk($sformatf("R%0d reset in_ready", R), 128'(in_ready), 128'h1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // known answers; in CTR mode the vector is loaded as the counter and XORed with zero
`ifdef AES_CTR_MODE_EN
      ld_req = 1'b1; ld_val = PT_B;
      send(KEY_B, 128'h0, 4'd5, 1'b1, 1'b1, CT_B);
`else
      send(KEY_B, PT_B, 4'd5, 1'b1, 1'b1, CT_B);
`endif
      latency_check("fips_b");
      drain();
      rdy_drv = 1'b0;
`ifdef AES_CTR_MODE_EN
      ld_req = 1'b1; ld_val = PT_C;
      send(KEY_C, 128'h0, 4'd6, 1'b1, 1'b1, CT_C);
`else
      send(KEY_C, PT_C, 4'd6, 1'b1, 1'b1, CT_C);
`endif
      latency_check("fips_c1");
      drain();

      // back-to-back with out_ready held high, tags 1..4
      n0 = nxfer;
      for (int i = 1; i <= 4; i++) send(rnd128(), rnd128(), 4'(i), 1'b1, 1'b0, '0);
      drain();
      chk($sformatf("R%0d b2b transfers", R), 128'(nxfer - n0), 128'd4);

      // backpressure: result held for 7 cycles with a second block waiting
      rdy_drv = 1'b0;
      send(rnd128(), rnd128(), 4'd7, 1'b1, 1'b0, '0);
      k = rnd128();
      d = rnd128();
      in_key = k; in_data = d; in_tag = 4'd8; in_valid = 1'b1;
      for (int i = 0; i < NCYC + 4 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        chk($sformatf("R%0d bp out_valid", R), 128'(out_valid), 128'h1);
        chk($sformatf("R%0d bp in_ready", R), 128'(in_ready), 128'h0);
        if (q.size() != 0) begin
          chk($sformatf("R%0d bp out_data", R), out_data, q[0].data);
          chk($sformatf("R%0d bp out_tag", R), 128'(out_tag), 128'(q[0].tag));
        end
      end
      @(posedge clk);
      #1;
      n0 = nxfer;
      rdy_drv = 1'b1;
      send(k, d, 4'd8, 1'b1, 1'b0, '0);
      rdy_drv = 1'b0;
      @(negedge clk);
      chk($sformatf("R%0d bp single transfer", R), 128'(nxfer - n0), 128'd1);
      chk($sformatf("R%0d bp valid dropped", R), 128'(out_valid), 128'h0);
      @(posedge clk);
      #1;
      drain();

      // random traffic, random backpressure and gaps, key wiggled outside accepts
      rr_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin
          in_key = rnd128();
          @(posedge clk);
          #1;
        end
`ifdef AES_CTR_MODE_EN
        ld_req = ($urandom_range(0, 7) == 0);
        ld_val = ($urandom_range(0, 1) == 0) ? {128{1'b1}} : rnd128();
`endif
        send(rnd128(), rnd128(), 4'($urandom), 1'b1, 1'b0, '0);
      end
      drain();

`ifdef AES_CTR_MODE_EN
      // counter loaded without an accept, then the SP 800-38A CTR vector
      ctr_load = 1'b1;
      ctr_init = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
      @(posedge clk);
      #1;
      ctr_load = 1'b0;
      ctr_m = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
      send(KEY_B, 128'h6bc1bee22e409f96e93d7e117393172a, 4'd9, 1'b1, 1'b1,
           128'h874d6191b620e3261bef6864990db6ce);
      drain();
      // all-ones counter wraps to zero for the following block
      ld_req = 1'b1;
      ld_val = {128{1'b1}};
      send(KEY_B, rnd128(), 4'd10, 1'b1, 1'b0, '0);
      d = rnd128();
      send(KEY_B, d, 4'd11, 1'b1, 1'b1, aes_ref(KEY_B, 128'h0) ^ d);
      drain();
`endif

      // reset during RUN cycle min(3, NCYC) aborts the block
      rdy_drv = 1'b0;
      kk = (NCYC >= 3) ? 3 : NCYC;
      send(rnd128(), rnd128(), 4'd12, 1'b0, 1'b0, '0);
      repeat (kk - 1) @(posedge clk);
      #1;
      chk($sformatf("R%0d busy before abort", R), 128'(busy), 128'h1);
      rst = 1'b1;
      #1;
      chk($sformatf("R%0d abort out_valid", R), 128'(out_valid), 128'h0);
      chk($sformatf("R%0d abort busy", R), 128'(busy), 128'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef AES_CTR_MODE_EN
      ctr_m = '0;
`endif
      @(negedge clk);
      chk($sformatf("R%0d in_ready after abort", R), 128'(in_ready), 128'h1);
      @(posedge clk);
      #1;
      n0 = nxfer;
      rdy_drv = 1'b1;
      send(rnd128(), rnd128(), 4'd13, 1'b1, 1'b0, '0);
      drain();
      chk($sformatf("R%0d transfers after abort", R), 128'(nxfer - n0), 128'd1);
      done[gi] = 1'b1;
    end
  end

  initial begin : watchdog
    int t;
    t = 0;
    while (!(done[0] && done[1] && done[2] && done[3]) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 50000) begin
      vecs++;
      errs++;
      $display("FAIL watchdog: drivers not finished after %0d cycles, expected completion", t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
